// File: rtl/serial_sub_ctrl_pkg.sv
// Package for the bit-serial subtractor: FSM state type and counter sizing.
`include "serial_sub_defs.vh"

package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = `SS_IDLE,
    RUN  = `SS_RUN,
    DONE = `SS_DONE
  } state_t;

  // Bit counter width: ceil(log2(w)), at least one bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_sub_1_bit.sv
// 1-bit full subtractor: x - y - cin.
// Ports: x, y, cin in; dif (difference bit), cout (borrow out).
module full_sub_1_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic dif,
  output logic cout
);

  assign dif  = x ^ y ^ cin;
  assign cout = (~x & y) | (~(x ^ y) & cin);

endmodule

// File: rtl/serial_sub_defs.vh
// Shared state encodings for serial_sub_ctrl.
// Kept as macros so the values stay visible whether this file is
// preprocessed on its own or pulled in through the package.
`ifndef SERIAL_SUB_DEFS_VH
`define SERIAL_SUB_DEFS_VH
`define SS_IDLE 2'd0
`define SS_RUN  2'd1
`define SS_DONE 2'd2
`endif

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, a, b     : request and operands, sampled in IDLE
//   busy            : operation in progress (RUN)
//   done            : one-cycle result-valid pulse (DONE)
//   diff/borrow/zero: held result of the last completed operation
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             fs_dif, fs_cout;
  logic [WIDTH-1:0] res_nxt;

  full_sub_1_bit u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (brw),
    .dif  (fs_dif),
    .cout (fs_cout)
  );

  // Result after this edge's bit enters at the MSB.
  assign res_nxt = {fs_dif, res_sh[WIDTH-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (cnt == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          res_sh <= '0;
          cnt    <= '0;
          brw    <= 1'b0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          brw    <= fs_cout;
          // Counter parks at LAST instead of wrapping; reloaded on next accept.
          if (cnt != LAST) cnt <= cnt + 1'b1;
          else begin
            diff   <= res_nxt;
            borrow <= fs_cout;
            zero   <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
